// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution / prediction unit.
// Holds the 3-bit branch condition codes, the 2-bit saturating counter
// encodings, the default operand width and the counter update helper.
package branch_resolve_unit_pkg;

    localparam int DEFAULT_WORD_LEN = 32;

    typedef enum logic [2:0] {
        COND_NONE = 3'd0,
        COND_JUMP = 3'd1,
        COND_BEZ  = 3'd2,
        COND_BNE  = 3'd3,
        COND_BEQ  = 3'd4,
        COND_BLTZ = 3'd5,
        COND_BGEZ = 3'd6,
        COND_BGTZ = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_e;

    // Saturating step of a 2-bit counter toward ST (taken) or SNT (not taken).
    function automatic cnt_e cntNext(input cnt_e c, input logic taken);
        if (taken)
            return (c == ST) ? ST : cnt_e'(c + 2'd1);
        else
            return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// branch_cond_eval: purely combinational branch condition evaluator.
// Ports:
//   reg1, reg2 : signed two's complement operands
//   brComm     : 3-bit condition code (cond_e)
//   taken      : condition outcome
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
    input  logic [WORD_LEN-1:0] reg1,
    input  logic [WORD_LEN-1:0] reg2,
    input  logic [2:0]          brComm,
    output logic                taken
);

    logic reg1Zero;
    logic reg1Neg;

    assign reg1Zero = (reg1 == '0);
    assign reg1Neg  = reg1[WORD_LEN-1];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(brComm))
            COND_NONE: taken = 1'b0;
            COND_JUMP: taken = 1'b1;
            COND_BEZ:  taken = reg1Zero;
            COND_BNE:  taken = (reg1 != reg2);
            COND_BEQ:  taken = (reg1 == reg2);
            COND_BLTZ: taken = reg1Neg;
            COND_BGEZ: taken = !reg1Neg;
            COND_BGTZ: taken = !reg1Neg && !reg1Zero;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches in ID and predicts them in IF.
// A direct-mapped table of 2-bit counters, tags and targets supplies the
// IF prediction; ID resolution produces the outcome, a mispredict flag,
// the redirect PC, and updates the table plus saturating statistics.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   if_pc / pred_taken / pred_target : fetch-side lookup
//   id_* , reg1, reg2, br_comm, stall : resolve-side inputs
//   br_cond, mispredict, redirect_pc  : resolve-side outputs
//   stats_clr, branch_cnt, mispred_cnt: statistics
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WORD_LEN  = DEFAULT_WORD_LEN,
    parameter int PC_LEN    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int STAT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_LEN-1:0]   if_pc,
    output logic                pred_taken,
    output logic [PC_LEN-1:0]   pred_target,
    input  logic                id_valid,
    input  logic                stall,
    input  logic [PC_LEN-1:0]   id_pc,
    input  logic [WORD_LEN-1:0] reg1,
    input  logic [WORD_LEN-1:0] reg2,
    input  logic [2:0]          br_comm,
    input  logic [PC_LEN-1:0]   id_target,
    input  logic                id_pred_taken,
    input  logic [PC_LEN-1:0]   id_pred_target,
    output logic                br_cond,
    output logic                mispredict,
    output logic [PC_LEN-1:0]   redirect_pc,
    input  logic                stats_clr,
    output logic [STAT_W-1:0]   branch_cnt,
    output logic [STAT_W-1:0]   mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = PC_LEN - IDX_W - 2;

    cnt_e              cntArr   [BHT_DEPTH];
    logic              validArr [BHT_DEPTH];
    logic [TAG_W-1:0]  tagArr   [BHT_DEPTH];
    logic [PC_LEN-1:0] tgtArr   [BHT_DEPTH];

    logic [IDX_W-1:0]  ifIdx, idIdx;
    logic [TAG_W-1:0]  ifTag, idTag;
    logic              condTaken;
    logic              resolving;
    logic              doUpdate;
    logic              idHit;
    logic              unusedPcBits;

    assign ifIdx = if_pc[IDX_W+1:2];
    assign ifTag = if_pc[PC_LEN-1:IDX_W+2];
    assign idIdx = id_pc[IDX_W+1:2];
    assign idTag = id_pc[PC_LEN-1:IDX_W+2];
    assign unusedPcBits = ^{if_pc[1:0], id_pc[1:0]};

    branch_cond_eval #(.WORD_LEN(WORD_LEN)) condEval (
        .reg1   (reg1),
        .reg2   (reg2),
        .brComm (br_comm),
        .taken  (condTaken)
    );

    // Fetch-side lookup reads the registered table, so a same-cycle update
    // at the same index is only visible after the edge.
    assign pred_taken  = validArr[ifIdx] && (tagArr[ifIdx] == ifTag) && cntArr[ifIdx][1];
    assign pred_target = pred_taken ? tgtArr[ifIdx] : if_pc + PC_LEN'(4);

    assign br_cond   = id_valid && condTaken;
    assign resolving = id_valid && (br_comm != COND_NONE);
    assign doUpdate  = resolving && !stall;
    assign idHit     = validArr[idIdx] && (tagArr[idIdx] == idTag);

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = id_pc + PC_LEN'(4);
        if (resolving) begin
            mispredict = (br_cond != id_pred_taken) ||
                         (br_cond && (id_pred_target != id_target));
            if (br_cond)
                redirect_pc = id_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                cntArr[IDX_W'(i)]   <= WNT;
                validArr[IDX_W'(i)] <= 1'b0;
                tagArr[IDX_W'(i)]   <= '0;
                tgtArr[IDX_W'(i)]   <= '0;
            end
        end else if (doUpdate) begin
            if (idHit) begin
                cntArr[idIdx] <= cntNext(cntArr[idIdx], br_cond);
                if (br_cond)
                    tgtArr[idIdx] <= id_target;
            end else if (br_cond) begin
                // Miss on a taken branch: claim the entry, starting at WT.
                cntArr[idIdx]   <= WT;
                validArr[idIdx] <= 1'b1;
                tagArr[idIdx]   <= idTag;
                tgtArr[idIdx]   <= id_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (stats_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (doUpdate) begin
            if (branch_cnt != '1)
                branch_cnt <= branch_cnt + STAT_W'(1);
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid;
    logic        stall;
    logic [31:0] id_pc;
    logic [31:0] reg1, reg2;
    logic [2:0]  br_comm;
    logic [31:0] id_target;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        br_cond;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        stats_clr;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] C_NONE = 3'd0, C_JUMP = 3'd1, C_BEZ = 3'd2, C_BNE = 3'd3,
                           C_BEQ = 3'd4, C_BLTZ = 3'd5, C_BGEZ = 3'd6, C_BGTZ = 3'd7;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .id_valid       (id_valid),
        .stall          (stall),
        .id_pc          (id_pc),
        .reg1           (reg1),
        .reg2           (reg2),
        .br_comm        (br_comm),
        .id_target      (id_target),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .br_cond        (br_cond),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .stats_clr      (stats_clr),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic setBranch(input logic [31:0] pc, input logic [2:0] cond,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] tgt, input logic pTaken,
                             input logic [31:0] pTgt);
        id_valid = 1'b1; id_pc = pc; br_comm = cond; reg1 = r1; reg2 = r2;
        id_target = tgt; id_pred_taken = pTaken; id_pred_target = pTgt;
    endtask

    task automatic idle();
        id_valid = 1'b0; br_comm = C_NONE; id_pred_taken = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; stats_clr = 1'b0; if_pc = 32'h100;
        id_pc = 32'h0; reg1 = '0; reg2 = '0; id_target = '0; id_pred_target = '0;
        idle();
        step(); step();
        rst = 1'b0;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0b want=0", pred_taken); end
        total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL reset_pred_target got=%h want=00000104", pred_target); end
        total++; if (br_cond !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL reset_id_out got=%0b%0b want=00", br_cond, mispredict); end
        total++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d want=0/0", branch_cnt, mispred_cnt); end
    endtask

    // Conditions are evaluated with stall=1 so the table stays clean.
    task automatic test_conditions();
        logic [2:0]  conds [10] = '{C_BLTZ, C_BGEZ, C_BGTZ, C_BNE, C_BEQ, C_BEZ, C_BGTZ, C_BGEZ, C_JUMP, C_NONE};
        logic [31:0] r1s   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                    32'h0, 32'h5, 32'h0, 32'h0, 32'h0};
        logic        exps  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            setBranch(32'h400, conds[i], r1s[i], 32'h0, 32'h480, 1'b0, 32'h0);
            #1;
            total++; if (br_cond !== exps[i]) begin bad++; $display("FAIL cond_%0d code=%0d got=%0b want=%0b", i, conds[i], br_cond, exps[i]); end
        end
        // NONE: no resolution, fall-through redirect
        total++; if (mispredict !== 1'b0 || redirect_pc !== 32'h404) begin bad++; $display("FAIL cond_none_redirect got=%0b/%h want=0/00000404", mispredict, redirect_pc); end
        // id_valid=0 masks the outcome
        setBranch(32'h400, C_JUMP, 32'h0, 32'h0, 32'h480, 1'b0, 32'h0);
        id_valid = 1'b0;
        #1;
        total++; if (br_cond !== 1'b0) begin bad++; $display("FAIL cond_invalid got=%0b want=0", br_cond); end
        // Right direction, wrong target still mispredicts
        setBranch(32'h400, C_BEQ, 32'h7, 32'h7, 32'h480, 1'b1, 32'h999);
        #1;
        total++; if (mispredict !== 1'b1 || redirect_pc !== 32'h480) begin bad++; $display("FAIL cond_bad_target got=%0b/%h want=1/00000480", mispredict, redirect_pc); end
        step();
        total++; if (branch_cnt !== 16'd0) begin bad++; $display("FAIL cond_stall_stats got=%0d want=0", branch_cnt); end
        stall = 1'b0;
        idle();
    endtask

    task automatic test_train();
        setBranch(32'h200, C_BEQ, 32'h5, 32'h5, 32'h240, 1'b0, 32'h0);
        #1;
        total++; if (mispredict !== 1'b1 || redirect_pc !== 32'h240) begin bad++; $display("FAIL train_first got=%0b/%h want=1/00000240", mispredict, redirect_pc); end
        step();
        idle(); if_pc = 32'h200;
        #1;
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin bad++; $display("FAIL train_pred got=%0b/%h want=1/00000240", pred_taken, pred_target); end
        setBranch(32'h200, C_BEQ, 32'h5, 32'h5, 32'h240, 1'b1, 32'h240);
        #1;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL train_second_mp got=%0b want=0", mispredict); end
        step();
        total++; if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd2) begin bad++; $display("FAIL train_stats got=%0d/%0d want=2/1", branch_cnt, mispred_cnt); end
        step();
        idle();
        #1;
        total++; if (pred_taken !== 1'b1 || branch_cnt !== 16'd3) begin bad++; $display("FAIL train_third got=%0b/%0d want=1/3", pred_taken, branch_cnt); end
    endtask

    task automatic test_saturation();
        // Counter is at ST; another taken must keep it there.
        setBranch(32'h200, C_BEQ, 32'h5, 32'h5, 32'h240, 1'b1, 32'h240);
        step();
        setBranch(32'h200, C_BEQ, 32'h5, 32'h6, 32'h240, 1'b1, 32'h240);
        #1;
        total++; if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin bad++; $display("FAIL sat_nt_redirect got=%0b/%h want=1/00000204", mispredict, redirect_pc); end
        step();
        idle();
        #1;
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_one_nt got=%0b want=1", pred_taken); end
        setBranch(32'h200, C_BEQ, 32'h5, 32'h6, 32'h240, 1'b1, 32'h240);
        step();
        idle();
        #1;
        total++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin bad++; $display("FAIL sat_two_nt got=%0b/%h want=0/00000204", pred_taken, pred_target); end
        total++; if (branch_cnt !== 16'd6 || mispred_cnt !== 16'd3) begin bad++; $display("FAIL sat_stats got=%0d/%0d want=6/3", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_alias();
        setBranch(32'h200, C_BEQ, 32'h5, 32'h5, 32'h240, 1'b0, 32'h0);
        step();
        setBranch(32'h300, C_BEQ, 32'h7, 32'h7, 32'h380, 1'b0, 32'h0);
        if_pc = 32'h200;
        #1;
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin bad++; $display("FAIL alias_same_cycle got=%0b/%h want=1/00000240", pred_taken, pred_target); end
        step();
        idle();
        #1;
        total++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin bad++; $display("FAIL alias_evicted got=%0b/%h want=0/00000204", pred_taken, pred_target); end
        if_pc = 32'h300;
        #1;
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h380) begin bad++; $display("FAIL alias_new got=%0b/%h want=1/00000380", pred_taken, pred_target); end
        total++; if (branch_cnt !== 16'd8 || mispred_cnt !== 16'd5) begin bad++; $display("FAIL alias_stats got=%0d/%0d want=8/5", branch_cnt, mispred_cnt); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        setBranch(32'h300, C_BEQ, 32'h1, 32'h2, 32'h380, 1'b1, 32'h380);
        #1;
        total++; if (mispredict !== 1'b1 || redirect_pc !== 32'h304) begin bad++; $display("FAIL stall_mp got=%0b/%h want=1/00000304", mispredict, redirect_pc); end
        step();
        total++; if (pred_taken !== 1'b1 || branch_cnt !== 16'd8 || mispred_cnt !== 16'd5) begin bad++; $display("FAIL stall_frozen got=%0b/%0d/%0d want=1/8/5", pred_taken, branch_cnt, mispred_cnt); end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        total++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || pred_taken !== 1'b1) begin bad++; $display("FAIL stall_clr got=%0d/%0d/%0b want=0/0/1", branch_cnt, mispred_cnt, pred_taken); end
        // Fall-through redirect wraps modulo 2^32
        setBranch(32'hFFFFFFFC, C_BNE, 32'h3, 32'h3, 32'h10, 1'b0, 32'h0);
        #1;
        total++; if (redirect_pc !== 32'h0 || mispredict !== 1'b0) begin bad++; $display("FAIL pc_wrap got=%h/%0b want=00000000/0", redirect_pc, mispredict); end
        stall = 1'b0;
        // Clear wins over a concurrent update; the table update still lands.
        setBranch(32'h300, C_BEQ, 32'h1, 32'h2, 32'h380, 1'b1, 32'h380);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        idle();
        #1;
        total++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0 || pred_taken !== 1'b0) begin bad++; $display("FAIL clr_priority got=%0d/%0d/%0b want=0/0/0", branch_cnt, mispred_cnt, pred_taken); end
    endtask

    task automatic test_async_reset();
        setBranch(32'h300, C_BEQ, 32'h1, 32'h1, 32'h380, 1'b0, 32'h0);
        step();
        idle();
        #1;
        total++; if (pred_taken !== 1'b1 || branch_cnt !== 16'd1) begin bad++; $display("FAIL areset_pre got=%0b/%0d want=1/1", pred_taken, branch_cnt); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin bad++; $display("FAIL areset_pred got=%0b/%h want=0/00000304", pred_taken, pred_target); end
        total++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin bad++; $display("FAIL areset_stats got=%0d/%0d want=0/0", branch_cnt, mispred_cnt); end
        // Update presented while reset is held must be discarded.
        setBranch(32'h300, C_BEQ, 32'h1, 32'h1, 32'h380, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        idle();
        #1;
        total++; if (pred_taken !== 1'b0 || branch_cnt !== 16'd0 || br_cond !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL areset_discard got=%0b/%0d/%0b/%0b want=0/0/0/0", pred_taken, branch_cnt, br_cond, mispredict); end
    endtask

    initial begin
        test_reset();
        test_conditions();
        test_train();
        test_saturation();
        test_alias();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
